// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: ALUOp/funct codes and the mul/div FSM state type.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package pipe_pkg;

   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   // Iteration count runs 0..31, one datapath step per count value.
   localparam logic [4:0] CNT_LAST = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIX  = 2'd2
   } md_state_t;

   // Two's-complement negate when neg is set; used both for operand
   // magnitudes on entry and for sign correction on exit.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Iterative 32x32 multiply / restoring divide datapath with final sign fix.
// Latency: one load cycle, then one acc step per step cycle; results are combinational from acc.
// Backpressure: none; the controlling FSM decides when to load and step.
module muldiv_dp
   import pipe_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load,
   input  logic        step,
   input  logic        op_div,
   input  logic        op_signed,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic [63:0] acc;
   logic [31:0] opnd;
   logic        is_div;
   logic        is_signed;
   logic        neg_a;
   logic        neg_b;
   logic        div_zero;

   logic        sa;
   logic        sb;
   logic [63:0] acc_next;
   logic [32:0] mul_sum;
   logic [32:0] div_part;
   logic [31:0] div_diff;
   logic [63:0] prod;
   logic        q_neg;

   assign sa = op_signed & opa[31];
   assign sb = op_signed & opb[31];

   // One iteration: shift-add for multiply, compare/subtract/shift for divide.
   always_comb begin
      mul_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
      div_part = acc[63:31];
      div_diff = div_part[31:0] - opnd;
      acc_next = acc;
      if (is_div) begin
         if (div_part >= {1'b0, opnd}) acc_next = {div_diff, acc[30:0], 1'b1};
         else                          acc_next = {acc[62:0], 1'b0};
      end else begin
         if (acc[0]) acc_next = {mul_sum, acc[31:1]};
         else        acc_next = {1'b0, acc[63:1]};
      end
   end

   // Latch magnitudes and op kind on load, advance the accumulator on step.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc       <= '0;
         opnd      <= '0;
         is_div    <= 1'b0;
         is_signed <= 1'b0;
         neg_a     <= 1'b0;
         neg_b     <= 1'b0;
         div_zero  <= 1'b0;
      end else if (load) begin
         is_div    <= op_div;
         is_signed <= op_signed;
         neg_a     <= sa;
         neg_b     <= sb;
         div_zero  <= op_div && (opb == 32'd0);
         // Divide keeps the dividend in acc low and the divisor aside;
         // multiply keeps the multiplier in acc low and the multiplicand aside.
         if (op_div) begin
            acc  <= {32'd0, mag32(opa, sa)};
            opnd <= mag32(opb, sb);
         end else begin
            acc  <= {32'd0, mag32(opb, sb)};
            opnd <= mag32(opa, sa);
         end
      end else if (step) begin
         acc <= acc_next;
      end
   end

   // Sign correction; a zero divisor leaves the all-ones quotient un-negated
   // and the remainder equal to the original dividend.
   always_comb begin
      prod  = (is_signed && (neg_a ^ neg_b)) ? (~acc + 64'd1) : acc;
      q_neg = is_signed & (neg_a ^ neg_b) & ~div_zero;
      if (is_div) begin
         res_hi = mag32(acc[63:32], neg_a);
         res_lo = mag32(acc[31:0], q_neg);
      end else begin
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Latency: 34 edges from accept to HI/LO update (accept, 32 steps, sign fix).
// Backpressure: stall_o holds muldiv starts and MFHI/MFLO while busy; other ops flow.
module ex_muldiv
   import pipe_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  ALUOp_i,
   input  logic [5:0]  funct_i,
   input  logic [31:0] Data1_i,
   input  logic [31:0] Data2_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy_o,
   output logic        stall_o
);

   md_state_t   state;
   logic [4:0]  cnt;
   logic        is_start;
   logic        is_read;
   logic        op_div;
   logic        op_signed;
   logic        load;
   logic        step;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   // Decode muldiv starts and HI/LO readers; only R-type funct fields count.
   always_comb begin
      is_start  = 1'b0;
      is_read   = 1'b0;
      op_div    = 1'b0;
      op_signed = 1'b0;
      if (ALUOp_i == ALUOP_RTYPE) begin
         case (funct_i)
            FUNCT_MULT:  begin is_start = 1'b1; op_signed = 1'b1; end
            FUNCT_MULTU: begin is_start = 1'b1; end
            FUNCT_DIV:   begin is_start = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
            FUNCT_DIVU:  begin is_start = 1'b1; op_div = 1'b1; end
            FUNCT_MFHI,
            FUNCT_MFLO:  begin is_read = 1'b1; end
            default:     ;
         endcase
      end
   end

   // Starts are taken only from IDLE, so a start held under stall is accepted once.
   assign load    = (state == ST_IDLE) && is_start;
   assign step    = (state == ST_BUSY);
   assign busy_o  = (state != ST_IDLE);
   assign stall_o = (state != ST_IDLE) && (is_start || is_read);

   // Control FSM: accept, count 32 steps, then commit the corrected result to HI/LO.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
         cnt   <= '0;
         hi_o  <= '0;
         lo_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (is_start) begin
                  cnt   <= '0;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               cnt <= cnt + 5'd1;
               if (cnt == CNT_LAST) state <= ST_FIX;
            end
            ST_FIX: begin
               hi_o  <= res_hi;
               lo_o  <= res_lo;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   muldiv_dp u_dp (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (load),
      .step      (step),
      .op_div    (op_div),
      .op_signed (op_signed),
      .opa       (Data1_i),
      .opb       (Data2_i),
      .res_hi    (res_hi),
      .res_lo    (res_lo)
   );

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed plus randomized check of ex_muldiv against an arithmetic reference.
// Latency: checks the 34-edge accept-to-result timing and 33-cycle stall windows.
// Backpressure: exercises stall on held starts/readers and no stall for other ops.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] d1;
   logic [31:0] d2;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ex_muldiv dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .ALUOp_i (aluop),
      .funct_i (funct),
      .Data1_i (d1),
      .Data2_i (d2),
      .hi_o    (hi),
      .lo_o    (lo),
      .busy_o  (busy),
      .stall_o (stall)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      int          sa;
      int          sb;
      logic [31:0] q;
      logic [31:0] r;
      sa = int'(a);
      sb = int'(b);
      case (f)
         6'h18: begin
            sp = longint'(sa) * longint'(sb);
            return 64'(sp);
         end
         6'h19: begin
            up = {32'd0, a} * {32'd0, b};
            return up;
         end
         6'h1A: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            return {r, q};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic idle_bus();
      aluop = 2'b10;
      funct = 6'h20;
      d1    = $urandom;
      d2    = $urandom;
   endtask

   // Issue one start op, then run other traffic and check timing and result.
   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      logic [31:0] hi0;
      logic [31:0] lo0;
      exp = model(f, a, b);
      hi0 = hi;
      lo0 = lo;
      aluop = 2'b10;
      funct = f;
      d1    = a;
      d2    = b;
      #1;
      chk({tag, " accept_stall"}, {63'd0, stall}, 64'd0);
      tick();
      idle_bus();
      #1;
      chk({tag, " busy_after_accept"}, {63'd0, busy}, 64'd1);
      chk({tag, " add_no_stall"}, {63'd0, stall}, 64'd0);
      repeat (32) tick();
      chk({tag, " busy_edge33"}, {63'd0, busy}, 64'd1);
      chk({tag, " hilo_held_edge33"}, {hi, lo}, {hi0, lo0});
      tick();
      chk({tag, " idle_edge34"}, {63'd0, busy}, 64'd0);
      chk({tag, " hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
      chk({tag, " lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
   endtask

   // Count consecutive sampled cycles with stall high, bounded.
   task automatic count_stall(output int n);
      n = 0;
      while (stall && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int          n;
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] e1;
      logic [63:0] e2;

      rst   = 1'b1;
      aluop = 2'b10;
      funct = 6'h18;
      d1    = 32'd3;
      d2    = 32'd4;
      #12;
      chk("reset hi", {32'd0, hi}, 64'd0);
      chk("reset lo", {32'd0, lo}, 64'd0);
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset stall", {63'd0, stall}, 64'd0);
      repeat (2) tick();
      chk("reset start ignored", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      aluop = 2'b00;
      funct = 6'h18;
      tick();
      chk("non_rtype funct18 no start", {63'd0, busy}, 64'd0);

      run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("mult_m3x7", 6'h18, 32'hFFFFFFFD, 32'd7);
      run_op("div_m7d2", 6'h1A, 32'hFFFFFFF9, 32'd2);
      run_op("divu_5d0", 6'h1B, 32'd5, 32'd0);
      run_op("div_m5d0", 6'h1A, 32'hFFFFFFFB, 32'd0);
      run_op("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
      run_op("div_7dm2", 6'h1A, 32'd7, 32'hFFFFFFFE);

      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 3))
            0:       f = 6'h18;
            1:       f = 6'h19;
            2:       f = 6'h1A;
            default: f = 6'h1B;
         endcase
         a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 9);
            default: b = $urandom;
         endcase
         run_op("random", f, a, b);
      end

      // MFLO right behind MULT 6x7.
      aluop = 2'b10;
      funct = 6'h18;
      d1    = 32'd6;
      d2    = 32'd7;
      tick();
      funct = 6'h12;
      #1;
      count_stall(n);
      chk("mflo stall cycles", 64'(n), 64'd33);
      chk("mflo stall dropped", {63'd0, stall}, 64'd0);
      chk("mflo lo", {32'd0, lo}, 64'd42);
      chk("mflo hi", {32'd0, hi}, 64'd0);

      // Back-to-back MULTU then DIVU held on the inputs.
      e1 = model(6'h19, 32'h12345678, 32'h9ABCDEF0);
      e2 = model(6'h1B, 32'hDEADBEEF, 32'd1000);
      funct = 6'h19;
      d1    = 32'h12345678;
      d2    = 32'h9ABCDEF0;
      tick();
      funct = 6'h1B;
      d1    = 32'hDEADBEEF;
      d2    = 32'd1000;
      #1;
      count_stall(n);
      chk("b2b stall cycles", 64'(n), 64'd33);
      chk("b2b first result", {hi, lo}, e1);
      chk("b2b idle before second", {63'd0, busy}, 64'd0);
      tick();
      idle_bus();
      #1;
      chk("b2b second accepted", {63'd0, busy}, 64'd1);
      repeat (33) tick();
      chk("b2b second done", {63'd0, busy}, 64'd0);
      chk("b2b second result", {hi, lo}, e2);

      // Reset between edges at step 10 of a MULT.
      aluop = 2'b10;
      funct = 6'h18;
      d1    = 32'h00012345;
      d2    = 32'hFFFF0001;
      tick();
      funct = 6'h10;
      repeat (10) tick();
      chk("pre_reset stall", {63'd0, stall}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("midreset busy", {63'd0, busy}, 64'd0);
      chk("midreset stall", {63'd0, stall}, 64'd0);
      chk("midreset hilo", {hi, lo}, 64'd0);
      #2;
      rst = 1'b0;
      funct = 6'h20;
      repeat (40) tick();
      chk("post_reset hilo", {hi, lo}, 64'd0);
      chk("post_reset busy", {63'd0, busy}, 64'd0);
      funct = 6'h10;
      #1;
      chk("idle mfhi no stall", {63'd0, stall}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have: clk_i  input  1  pipeline clock; all state updates on posedge.
REQ-002 SHALL have: rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: ALUOp_i  input  2  ALUOp from ID/EX register; 2'b10 = R-type.
REQ-004 SHALL have: funct_i  input  6  funct from ID/EX register.
REQ-005 SHALL have: Data1_i  input  32  rs operand (dividend / multiplicand).
REQ-006 SHALL have: Data2_i  input  32  rt operand (divisor / multiplier).
REQ-007 SHALL have: hi_o  output  32  HI register, registered.
REQ-008 SHALL have: lo_o  output  32  LO register, registered.
REQ-009 SHALL have: busy_o  output  1  operation in flight (state != IDLE).
REQ-010 SHALL have: stall_o  output  1  combinational; freeze PC/IF_ID/ID_EX, bubble into EX/MEM.

Function
REQ-011 SHALL decode, only when ALUOp_i==2'b10: MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B (start ops); MFHI 6'h10, MFLO 6'h12 (readers).
REQ-012 SHALL implement FSM states IDLE, BUSY, FIX.
REQ-013 IDLE + start op: SHALL accept that edge, latch operand magnitudes, signed flag, op kind; cnt<=0; ->BUSY; stall_o low in accept cycle.
REQ-014 BUSY: SHALL perform one shift-add (mult) or restoring-subtract (div) step per cycle; exactly 32 steps; ->FIX after step 32 (cnt==31).
REQ-015 FIX: SHALL apply sign correction, write hi_o/lo_o, ->IDLE; total 34 edges from accept to result visible (accept, 32 steps, FIX).
REQ-016 Mult: {hi,lo} SHALL equal full 64-bit product; signed for MULT, unsigned for MULTU.
REQ-017 Div: lo=quotient, hi=remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-018 Divide by zero (either DIV/DIVU): SHALL give lo=32'hFFFFFFFF, hi=Data1_i as latched; no exception.
REQ-019 DIV 32'h80000000 / 32'hFFFFFFFF: SHALL give lo=32'h80000000, hi=0.
REQ-020 stall_o SHALL be high when state != IDLE and decoded op is a start op, MFHI or MFLO; low otherwise.
REQ-021 Start op held under stall SHALL be accepted on the first edge state==IDLE; never accepted twice (accept only from IDLE).
REQ-022 Non-muldiv instructions SHALL proceed without stall while busy; hi_o/lo_o unchanged until FIX.
REQ-023 hi_o/lo_o SHALL change only in FIX or reset.

Reset
REQ-024 rst_i high SHALL immediately force state=IDLE, cnt=0, hi_o=0, lo_o=0, busy_o=0, internal datapath regs=0, independent of clk_i.
REQ-025 Reset mid-operation SHALL abandon the operation; no partial result reaches hi_o/lo_o.
REQ-026 stall_o SHALL be 0 throughout reset.

Structure
REQ-027 funct codes, ALUOp codes, FSM state encoding SHALL live in shared package pipe_pkg.
REQ-028 Control FSM/decoder in ex_muldiv; iteration datapath (64-bit accumulator, step logic, sign fix) SHALL be sub-module muldiv_dp.
REQ-029 HI/LO SHALL reside only in ex_muldiv; forwarding unit reads hi_o/lo_o for MFHI/MFLO.

Verification
REQ-030 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> after 34 edges hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-031 MULT -3 x 7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-032 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 5 / 0 -> lo=32'hFFFFFFFF, hi=32'h00000005.
REQ-033 MFLO presented cycle after MULT 6x7 accept -> stall_o high 33 cycles, drops with lo=42 same cycle; ADD during busy -> no stall.
REQ-034 Back-to-back MULTU then DIVU held on inputs -> second stalls 33 cycles, accepted once, both results correct in order.
REQ-035 rst_i pulsed between clock edges at step 10 -> busy_o, stall_o, hi_o, lo_o zero immediately; no later result write.
